// File: rtl/mem_resp_pkg.sv
// Shared types and helpers for the mem_responder slice: FSM state encoding,
// default bus widths and the address error check.
package mem_resp_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Misaligned byte address, or word index beyond the array (no aliasing).
  function automatic logic addr_err(input logic [63:0] addr, input int unsigned depth_words);
    logic [63:0] widx;
    widx = addr >> 2;
    return (addr[1:0] != 2'b00) || (widx >= 64'(depth_words));
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response handshake bundle between a load/store initiator and mem_responder.
// The req_be lane exists only when MEM_RESPONDER_BYTE_STROBE_EN is defined.
interface mem_responder_if
  import mem_resp_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
`ifdef MEM_RESPONDER_BYTE_STROBE_EN
  logic [3:0]        req_be;
`endif
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
`ifdef MEM_RESPONDER_BYTE_STROBE_EN
    output req_be,
`endif
    output req_valid, req_we, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
`ifdef MEM_RESPONDER_BYTE_STROBE_EN
    input  req_be,
`endif
    input  req_valid, req_we, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/mem_resp_storage.sv
// Word-addressed data array: synchronous per-byte write, asynchronous read of
// the presented index. Contents are deliberately not reset.
module mem_resp_storage
  import mem_resp_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic                clk,
  input  logic                we_i,
  input  logic [IDX_W-1:0]    idx_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] be_i,
  output logic [DATA_W-1:0]   rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

  // Byte-lane write of the selected word.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < DATA_W / 8; b++) begin
        if (be_i[b]) begin
          mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/mem_responder.sv
// Handshaked, fixed-latency data-memory responder (one outstanding request).
// Optional byte strobes: define MEM_RESPONDER_BYTE_STROBE_EN.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic          clk,
  input  logic          rst,
  mem_responder_if.slave bus
);

  localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              resp_valid_q;
  logic [DATA_W-1:0] resp_rdata_q;
  logic              resp_err_q;

  logic              access_s;
  logic              err_s;
  logic              mem_we_s;
  logic [IDX_W-1:0]  idx_s;
  logic [3:0]        be_s;
  logic [DATA_W-1:0] mem_rdata_s;

`ifdef MEM_RESPONDER_BYTE_STROBE_EN
  logic [3:0]        be_q;
  assign be_s = be_q;
`else
  assign be_s = 4'hF;
`endif

  assign idx_s    = addr_q[IDX_W+1:2];
  assign err_s    = addr_err(64'(addr_q), DEPTH_WORDS);
  assign access_s = (state_q == WAIT) && (cnt_q == 4'd0);
  // Gating with rst keeps a write that is still pending from committing under reset.
  assign mem_we_s = rst && access_s && we_q && !err_s;

  assign bus.req_ready  = rst && (state_q == IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;

  mem_resp_storage #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .DATA_W      (DATA_W),
    .IDX_W       (IDX_W)
  ) u_storage (
    .clk     (clk),
    .we_i    (mem_we_s),
    .idx_i   (idx_s),
    .wdata_i (wdata_q),
    .be_i    (be_s),
    .rdata_o (mem_rdata_s)
  );

  // Request latch, latency counter and registered response.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
`ifdef MEM_RESPONDER_BYTE_STROBE_EN
      be_q         <= 4'h0;
`endif
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            we_q    <= bus.req_we;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
`ifdef MEM_RESPONDER_BYTE_STROBE_EN
            be_q    <= bus.req_be;
`endif
            cnt_q   <= LAT_M1;
            state_q <= WAIT;
          end else begin
            state_q <= IDLE;
          end
        end
        WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= err_s;
            resp_rdata_q <= (we_q || err_s) ? '0 : mem_rdata_s;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            state_q      <= IDLE;
          end else begin
            state_q <= RESP;
          end
        end
        default: begin
          state_q      <= IDLE;
          cnt_q        <= 4'd0;
          resp_valid_q <= 1'b0;
          resp_rdata_q <= '0;
          resp_err_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed + randomized bench for mem_responder against a word-array reference model;
// three instances (LATENCY 2, 1, 15) share stimulus for the latency sweep.
module tb_mem_responder;

  localparam int LAT   = 2;
  localparam int DEPTH = 256;
`ifdef MEM_RESPONDER_BYTE_STROBE_EN
  localparam bit STROBE = 1'b1;
`else
  localparam bit STROBE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we, resp_ready;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [DEPTH];
  bit          known [DEPTH];

  always #5 clk = ~clk;

  mem_responder_if #(.ADDR_W(32), .DATA_W(32)) bus2 ();
  mem_responder_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();
  mem_responder_if #(.ADDR_W(32), .DATA_W(32)) bus15 ();

  assign bus2.req_valid  = req_valid;  assign bus1.req_valid  = req_valid;  assign bus15.req_valid  = req_valid;
  assign bus2.req_we     = req_we;     assign bus1.req_we     = req_we;     assign bus15.req_we     = req_we;
  assign bus2.req_addr   = req_addr;   assign bus1.req_addr   = req_addr;   assign bus15.req_addr   = req_addr;
  assign bus2.req_wdata  = req_wdata;  assign bus1.req_wdata  = req_wdata;  assign bus15.req_wdata  = req_wdata;
  assign bus2.resp_ready = resp_ready; assign bus1.resp_ready = resp_ready; assign bus15.resp_ready = resp_ready;
`ifdef MEM_RESPONDER_BYTE_STROBE_EN
  assign bus2.req_be = req_be; assign bus1.req_be = req_be; assign bus15.req_be = req_be;
`endif

  mem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(DEPTH), .LATENCY(2))  u_dut   (.clk(clk), .rst(rst), .bus(bus2));
  mem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(DEPTH), .LATENCY(1))  u_lat1  (.clk(clk), .rst(rst), .bus(bus1));
  mem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(DEPTH), .LATENCY(15)) u_lat15 (.clk(clk), .rst(rst), .bus(bus15));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic garbage();
    req_valid = 1'($urandom);
    req_we    = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_be    = 4'($urandom);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // One full transaction on the LATENCY=2 instance; called at a negedge.
  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, input int hold);
    int          n;
    logic [31:0] idx, exp_rdata;
    logic        exp_err, rd_known;
    logic [3:0]  be_eff;
    idx       = addr >> 2;
    exp_err   = (addr[1:0] != 2'b00) || (idx >= 32'(DEPTH));
    be_eff    = STROBE ? be : 4'hF;
    exp_rdata = 32'h0;
    rd_known  = 1'b1;
    if (!exp_err && !we) begin
      exp_rdata = model[idx[7:0]];
      rd_known  = known[idx[7:0]];
    end
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    n = 0;
    while (bus2.req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk("accept_wait", 64'(n < 50), 64'd1);
    @(posedge clk);
    @(negedge clk);
    n = 0;
    while (bus2.resp_valid !== 1'b1 && n < 40) begin
      garbage();
      @(negedge clk);
      n++;
    end
    chk("latency", 64'(n), 64'(LAT));
    chk("resp_err", 64'(bus2.resp_err), 64'(exp_err));
    if (rd_known) chk("resp_rdata", 64'(bus2.resp_rdata), 64'(exp_rdata));
    chk("req_ready_busy", 64'(bus2.req_ready), 64'd0);
    for (int h = 0; h < hold; h++) begin
      garbage();
      @(negedge clk);
      chk("hold_valid", 64'(bus2.resp_valid), 64'd1);
      chk("hold_err", 64'(bus2.resp_err), 64'(exp_err));
      if (rd_known) chk("hold_rdata", 64'(bus2.resp_rdata), 64'(exp_rdata));
      chk("hold_req_ready", 64'(bus2.req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid  = 1'b0;
    chk("after_hs_valid", 64'(bus2.resp_valid), 64'd0);
    chk("after_hs_ready", 64'(bus2.req_ready), 64'd1);
    if (we && !exp_err) begin
      model[idx[7:0]] = merge(model[idx[7:0]], wdata, be_eff);
      known[idx[7:0]] = known[idx[7:0]] | (be_eff == 4'hF);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int f1, f2, f15, n, r;
    logic [31:0] a, prior;
    for (int i = 0; i < DEPTH; i++) begin model[i] = 32'h0; known[i] = 1'b0; end
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0;
    req_wdata = 32'h0; req_be = 4'hF; resp_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(bus2.resp_valid), 64'd0);
    chk("rst_rdata", 64'(bus2.resp_rdata), 64'd0);
    chk("rst_err", 64'(bus2.resp_err), 64'd0);
    chk("rst_ready", 64'(bus2.req_ready), 64'd0);
    chk("rst_ready15", 64'(bus15.req_ready), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 64'(bus2.req_ready), 64'd1);
    chk("ready_after_rst1", 64'(bus1.req_ready), 64'd1);

    // Latency sweep: one write accepted by all three, req inputs toggled while busy
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0; req_wdata = 32'h0; req_be = 4'hF;
    @(posedge clk);
    @(negedge clk);
    model[0] = 32'h0; known[0] = 1'b1;
    f1 = 0; f2 = 0; f15 = 0;
    for (int k = 1; k <= 17; k++) begin
      garbage();
      @(negedge clk);
      if (bus1.resp_valid === 1'b1 && f1 == 0) f1 = k;
      if (bus2.resp_valid === 1'b1 && f2 == 0) f2 = k;
      if (bus15.resp_valid === 1'b1 && f15 == 0) f15 = k;
    end
    chk("sweep_lat1", 64'(f1), 64'd1);
    chk("sweep_lat2", 64'(f2), 64'd2);
    chk("sweep_lat15", 64'(f15), 64'd15);
    chk("sweep_hold1", 64'(bus1.resp_valid), 64'd1);
    chk("sweep_err2", 64'(bus2.resp_err), 64'd0);
    chk("sweep_rdata2", 64'(bus2.resp_rdata), 64'd0);
    req_valid = 1'b0; resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    chk("sweep_drop1", 64'(bus1.resp_valid), 64'd0);
    chk("sweep_drop15", 64'(bus15.resp_valid), 64'd0);

    // Write/read, backpressure, boundary index
    xact(1'b1, 32'h10, 32'h000000AB, 4'hF, 0);
    xact(1'b0, 32'h10, 32'h0, 4'hF, 0);
    chk("rd_0x10_ab", 64'(model[4]), 64'h000000AB);
    xact(1'b0, 32'h10, 32'h0, 4'hF, 5);
    xact(1'b1, 32'h3FC, 32'hCAFEF00D, 4'hF, 1);
    xact(1'b0, 32'h3FC, 32'h0, 4'hF, 0);

    // Error accesses leave storage untouched
    xact(1'b1, 32'h12, 32'h55555555, 4'hF, 0);
    xact(1'b1, 32'h400, 32'h66666666, 4'hF, 0);
    xact(1'b0, 32'h401, 32'h0, 4'hF, 0);
    xact(1'b0, 32'h10, 32'h0, 4'hF, 0);
    xact(1'b0, 32'h0, 32'h0, 4'hF, 0);

    // Reset one cycle after accepting a write
    prior = $urandom;
    xact(1'b1, 32'h20, prior, 4'hF, 0);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hDEADBEEF; req_be = 4'hF;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk("midrst_valid", 64'(bus2.resp_valid), 64'd0);
    chk("midrst_ready", 64'(bus2.req_ready), 64'd0);
    rst = 1'b1;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus2.resp_valid === 1'b1) n++;
    end
    chk("midrst_no_resp", 64'(n), 64'd0);
    xact(1'b0, 32'h20, 32'h0, 4'hF, 0);
    chk("midrst_prior", 64'(model[8]), 64'(prior));

`ifdef MEM_RESPONDER_BYTE_STROBE_EN
    xact(1'b1, 32'h30, 32'h11223344, 4'b1111, 0);
    xact(1'b1, 32'h30, 32'hAABBCCDD, 4'b0101, 0);
    xact(1'b1, 32'h30, 32'hFFFFFFFF, 4'b0000, 0);
    xact(1'b0, 32'h30, 32'h0, 4'b0000, 0);
    chk("strobe_merge", 64'(model[12]), 64'h11BB33DD);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 16; i++) xact(1'b1, 32'(i * 4), $urandom, 4'hF, 0);
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 6)      a = 32'($urandom_range(0, 15) * 4);
      else if (r == 7) a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
      else if (r == 8) a = 32'((256 + $urandom_range(0, 1000)) * 4);
      else             a = $urandom | 32'h8000_0000;
      xact(1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the CPU's load/store data path, replacing the zero-wait data memory with a handshaked, latency-configurable target.
- Accepts one word request at a time over a valid/ready request channel.
- Performs the read or write after a fixed programmable delay.
- Returns the result over a valid/ready response channel. Internal word-addressed storage.

Parameters:
- ADDR_W, 32, byte-address width (matches ALU output width)
- DATA_W, 32, data word width; fixed at 32
- DEPTH_WORDS, 256, number of 32-bit words stored; power of two
- LATENCY, 2, cycles from request acceptance to response valid; legal range 1..15

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset; synchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  byte address, word-aligned expected
- req_wdata  in  DATA_W  write data
- resp_valid  out  1  response present
- resp_ready  in  1  initiator accepts response
- resp_rdata  out  DATA_W  read data; 0 for writes and errors
- resp_err  out  1  misaligned or out-of-range access

Behaviour:
- Reset values (rst=0 sampled at a clk edge): state=IDLE, counter=0, req_ready=0 while rst=0, resp_valid=0, resp_rdata=0, resp_err=0. Storage contents are not reset.
- FSM has three states: IDLE, WAIT, RESP. req_ready = (state==IDLE) && rst.
- IDLE: on req_valid && req_ready, latch we/addr/wdata, load counter with LATENCY-1, go to WAIT. Otherwise remain in IDLE.
- WAIT: if counter != 0, decrement. If counter == 0, perform the access and go to RESP. For a request accepted at edge T, resp_valid is high after edge T+LATENCY.
- Access rules:
  - Word index = addr[log2(DEPTH_WORDS)+1:2].
  - err = (addr[1:0] != 0) || (addr[ADDR_W-1:2] >= DEPTH_WORDS).
  - Read OK: rdata = mem[index], err = 0.
  - Write OK: mem[index] <= wdata, rdata = 0, err = 0.
  - Error: no storage change, rdata = 0, err = 1.
- RESP: hold resp_valid, resp_rdata and resp_err stable until resp_ready=1. On the handshake edge, resp_valid <= 0 and state goes to IDLE. req_ready rises the following cycle.
- No pipelining: one outstanding request. Minimum request-to-request spacing is LATENCY+2 cycles.
- A write followed by a read to the same address returns the new data (the write commits before the read is accepted).
- req_* inputs are ignored outside IDLE. Changes to them after acceptance have no effect.
- Reset mid-operation: returns to IDLE, and any response is dropped. A write still in WAIT is not committed. A write already performed stays committed.
- Wrap-around: addresses beyond the storage range are never aliased; they error.

Optional Feature:
- Macro: MEM_RESPONDER_BYTE_STROBE_EN.
- Defined:
  - Adds port req_be, in, 4 bits, byte enables; req_be[i] writes byte i (bits 8i+7:8i).
  - Bytes with req_be[i]=0 keep their old value.
  - req_be=0000 on a write is a legal no-op with err=0.
  - Reads ignore req_be and return the full word.
- Undefined: port absent; every write is a full-word write.

Decomposition:
- Shared package mem_resp_pkg holds:
  - state enum (IDLE=2'd0, WAIT=2'd1, RESP=2'd2)
  - DATA_W/ADDR_W defaults
  - error-check helper function (alignment and range)
- One sub-module: mem_resp_storage. This is a synchronous word array with write port, per-byte write enables tied high when strobes are compiled out, and an asynchronous read of the latched index.
- The FSM and counter stay in the top.

Test Plan:
- Reset then write/read, LATENCY=2: rst=0 for 2 cycles then 1; write 0x000000AB to addr 0x10, then read 0x10. resp_valid rises exactly 2 cycles after each acceptance; read returns 0x000000AB with err=0.
- Backpressure: read accepted, resp_ready held 0 for 5 cycles. resp_valid, rdata and err stay stable the whole time; req_ready stays 0; the next request is accepted only the cycle after the handshake.
- Errors: write to addr 0x12 (misaligned) and to addr 0x400 (index 256 with DEPTH_WORDS=256). err=1, rdata=0, and a subsequent read of 0x10 and 0x0 shows unchanged contents.
- Reset mid-WAIT: write 0xDEADBEEF to addr 0x20, assert rst=0 one cycle after acceptance. No response is produced; a later read of 0x20 returns the prior value.
- Latency sweep: LATENCY=1 and LATENCY=15 builds; acceptance-to-resp_valid is exactly 1 and 15 cycles. req_valid toggled during WAIT is ignored.
- Byte strobes (macro defined): write 0x11223344 with be=1111, then 0xAABBCCDD with be=0101. Read returns 0x11BB33DD.
